// File: rtl/inv_mon_pkg.sv
// inv_mon_pkg: shared types and helpers for the inverter edge monitor.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: width FSM state enum, filter-counter width helper, saturating increment.
package inv_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    DONE = 2'd2
  } wstate_t;

  // Width of the glitch-filter run counter; it must hold 0..FILTER_LEN.
  function automatic int fc_width(input int filter_len);
    return $clog2(filter_len + 1);
  endfunction

  // Increment v, holding at the all-ones value of a w-bit field.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] maxv;
    maxv = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= maxv) ? maxv : (v + 32'd1);
  endfunction

endpackage

// File: rtl/inv_mon_sync.sv
// inv_mon_sync: two-flop synchronizer for the asynchronous inverter output.
// Latency: 2 clk edges from i_d to o_q.
// Backpressure: none; free-running sampler.
// Ports: clk, rst_n (async active-low, clears both flops), i_d (async input), o_q (synchronized level).
module inv_mon_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      o_q  <= 1'b0;
    end else begin
      r_s1 <= i_d;
      o_q  <= r_s1;
    end
  end

endmodule

// File: rtl/inv_edge_monitor.sv
// inv_edge_monitor: deglitches the inverter output, counts edges, measures high-pulse width.
// Latency: in -> out_filt/edge pulse is 2+FILTER_LEN edges; width_valid one edge after the fall.
// Backpressure: none; all outputs are free-running status.
// Ports: clk, rst_n (async active-low), in (async raw level), clr (sync clear of counters/width/overflow);
//        out_filt, rise_pulse, fall_pulse, rise_cnt, fall_cnt, high_width, width_valid, overflow (sticky).
// Optional: define INV_MON_GLITCH_CNT_EN to add glitch_cnt (count of rejected runs).
module inv_edge_monitor
  import inv_mon_pkg::*;
#(
  parameter int FILTER_LEN = 3,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic             clr,
  output logic             out_filt,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic [CNT_W-1:0] high_width,
  output logic             width_valid,
`ifdef INV_MON_GLITCH_CNT_EN
  output logic [CNT_W-1:0] glitch_cnt,
`endif
  output logic             overflow
);

  localparam int              FC_W    = fc_width(FILTER_LEN);
  // Accepting on fc == FILTER_LEN-1 is the same as fc+1 == FILTER_LEN without widening.
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             w_s;
  logic             w_differ;
  logic             w_accept;
  logic             w_rise;
  logic             w_fall;
  logic             w_ovf_cnt;
  logic             w_ovf_wacc;
  logic             w_ovf_glitch;
  logic [FC_W-1:0]  r_fc;
  logic [CNT_W-1:0] r_wacc;
  wstate_t          r_state;

  inv_mon_sync u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (in),
    .o_q  (w_s)
  );

  assign w_differ = (w_s != out_filt);
  assign w_accept = w_differ && (r_fc == FC_LAST);
  assign w_rise   = w_accept && !out_filt;
  assign w_fall   = w_accept && out_filt;

  // Glitch filter: a level change is accepted only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fc       <= '0;
      out_filt   <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= w_rise;
      fall_pulse <= w_fall;
      if (w_accept) begin
        out_filt <= !out_filt;
        r_fc     <= '0;
      end else if (w_differ) begin
        r_fc <= r_fc + 1'b1;
      end else begin
        r_fc <= '0;
      end
    end
  end

  // Edge counters; clr takes priority so a coincident edge is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_cnt <= '0;
      fall_cnt <= '0;
    end else if (clr) begin
      rise_cnt <= '0;
      fall_cnt <= '0;
    end else begin
      if (w_rise) rise_cnt <= CNT_W'(sat_inc(32'(rise_cnt), CNT_W));
      if (w_fall) fall_cnt <= CNT_W'(sat_inc(32'(fall_cnt), CNT_W));
    end
  end

  // Width FSM. The cycle out_filt rises loads wacc=1; each further high cycle adds one,
  // so at the fall wacc equals the number of cycles out_filt was high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_wacc      <= '0;
      high_width  <= '0;
      width_valid <= 1'b0;
    end else begin
      width_valid <= 1'b0;
      if (clr) high_width <= '0;
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state <= MEAS;
            r_wacc  <= CNT_W'(1);
          end
        end
        MEAS: begin
          if (clr)          r_wacc <= '0;
          else if (!w_fall) r_wacc <= CNT_W'(sat_inc(32'(r_wacc), CNT_W));
          if (w_fall) r_state <= DONE;
        end
        DONE: begin
          width_valid <= 1'b1;
          if (!clr) high_width <= r_wacc;
          // Back-to-back rise is only reachable with FILTER_LEN=1.
          if (w_rise) begin
            r_state <= MEAS;
            r_wacc  <= CNT_W'(1);
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_ovf_cnt  = (w_rise && (rise_cnt == CNT_MAX)) || (w_fall && (fall_cnt == CNT_MAX));
  assign w_ovf_wacc = (r_state == MEAS) && !w_fall && (r_wacc == CNT_MAX);

`ifdef INV_MON_GLITCH_CNT_EN
  logic w_reject;

  // A non-empty run of differing samples that ends before acceptance.
  assign w_reject     = !w_differ && (r_fc != '0);
  assign w_ovf_glitch = w_reject && (glitch_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt <= '0;
    end else if (clr) begin
      glitch_cnt <= '0;
    end else if (w_reject) begin
      glitch_cnt <= CNT_W'(sat_inc(32'(glitch_cnt), CNT_W));
    end
  end
`else
  assign w_ovf_glitch = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (clr) begin
      overflow <= 1'b0;
    end else if (w_ovf_cnt || w_ovf_wacc || w_ovf_glitch) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inv_edge_monitor.sv
// tb_inv_edge_monitor: directed bench for inv_edge_monitor with FILTER_LEN=3, CNT_W=8.
// Inputs change 1 time unit after a rising edge; outputs are read at the same offset.
// Expected values are hand-derived cycle counts for each directed step.
module tb_inv_edge_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in;
  logic       clr;
  logic       out_filt;
  logic       rise_pulse;
  logic       fall_pulse;
  logic [7:0] rise_cnt;
  logic [7:0] fall_cnt;
  logic [7:0] high_width;
  logic       width_valid;
  logic       overflow;
`ifdef INV_MON_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  inv_edge_monitor #(.FILTER_LEN(3), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in),
    .clr        (clr),
    .out_filt   (out_filt),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .rise_cnt   (rise_cnt),
    .fall_cnt   (fall_cnt),
    .high_width (high_width),
    .width_valid(width_valid),
`ifdef INV_MON_GLITCH_CNT_EN
    .glitch_cnt (glitch_cnt),
`endif
    .overflow   (overflow)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;

    rst_n = 1'b0;
    in    = 1'b0;
    clr   = 1'b0;
    step(3);
    check("rst_out_filt", out_filt, 0);
    check("rst_rise_pulse", rise_pulse, 0);
    check("rst_fall_pulse", fall_pulse, 0);
    check("rst_rise_cnt", rise_cnt, 0);
    check("rst_fall_cnt", fall_cnt, 0);
    check("rst_high_width", high_width, 0);
    check("rst_width_valid", width_valid, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    step(5);
    check("post_rst_out_filt", out_filt, 0);

    // Clean rise: accepted on the 5th edge after in changes.
    in = 1'b1;
    step(4);
    check("t1_out_filt_edge4", out_filt, 0);
    step(1);
    check("t1_out_filt_edge5", out_filt, 1);
    check("t1_rise_pulse", rise_pulse, 1);
    check("t1_fall_pulse", fall_pulse, 0);
    step(1);
    check("t1_rise_pulse_gone", rise_pulse, 0);
    check("t1_rise_cnt", rise_cnt, 1);
    check("t1_fall_cnt", fall_cnt, 0);

    // Fall; the first high level after reset (6 cycles) is measured.
    in = 1'b0;
    step(4);
    check("t2_out_filt_hold", out_filt, 1);
    step(1);
    check("t2_out_filt_fall", out_filt, 0);
    check("t2_fall_pulse", fall_pulse, 1);
    check("t2_rise_pulse", rise_pulse, 0);
    step(1);
    check("t2_first_wv", width_valid, 1);
    check("t2_first_width", high_width, 6);
    step(34);
    // 20-cycle high pulse.
    in = 1'b1;
    step(5);
    check("t2_rise", out_filt, 1);
    check("t2_rise_cnt", rise_cnt, 2);
    step(15);
    in = 1'b0;
    step(4);
    check("t2_hold_high", out_filt, 1);
    check("t2_wv_early", width_valid, 0);
    step(1);
    check("t2_fall2", out_filt, 0);
    check("t2_wv_at_fall", width_valid, 0);
    step(1);
    check("t2_wv", width_valid, 1);
    check("t2_high_width", high_width, 20);
    step(1);
    check("t2_wv_one_cycle", width_valid, 0);
    check("t2_fall_cnt", fall_cnt, 2);
    check("t2_overflow", overflow, 0);

    // 2-cycle glitch is rejected.
    in = 1'b1;
    step(2);
    in = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (out_filt) seen = 1'b1;
    end
    check("t3_glitch_out_filt", seen, 0);
    check("t3_rise_cnt", rise_cnt, 2);
    check("t3_fall_cnt", fall_cnt, 2);
`ifdef INV_MON_GLITCH_CNT_EN
    check("t3_glitch_cnt", glitch_cnt, 1);
`endif

    // 300 clean toggles saturate both edge counters.
    for (int i = 0; i < 300; i++) begin
      in = 1'b1;
      step(10);
      in = 1'b0;
      step(10);
    end
    step(10);
    check("t4_rise_cnt_sat", rise_cnt, 255);
    check("t4_fall_cnt_sat", fall_cnt, 255);
    check("t4_overflow", overflow, 1);
    check("t4_high_width", high_width, 10);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("t4_clr_rise_cnt", rise_cnt, 0);
    check("t4_clr_fall_cnt", fall_cnt, 0);
    check("t4_clr_high_width", high_width, 0);
    check("t4_clr_overflow", overflow, 0);
`ifdef INV_MON_GLITCH_CNT_EN
    check("t4_clr_glitch_cnt", glitch_cnt, 0);
`endif

    // 300-cycle high pulse saturates the width accumulator.
    in = 1'b1;
    step(300);
    check("t5_overflow_meas", overflow, 1);
    check("t5_rise_cnt", rise_cnt, 1);
    in = 1'b0;
    step(6);
    check("t5_wv", width_valid, 1);
    check("t5_high_width_sat", high_width, 255);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("t5_clr_overflow", overflow, 0);

    // Reset in the middle of a measurement discards it.
    in = 1'b1;
    step(10);
    check("t6_meas_high", out_filt, 1);
    rst_n = 1'b0;
    step(2);
    check("t6_rst_out_filt", out_filt, 0);
    check("t6_rst_rise_cnt", rise_cnt, 0);
    check("t6_rst_width_valid", width_valid, 0);
    in = 1'b0;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (width_valid) seen = 1'b1;
    end
    in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (width_valid) seen = 1'b1;
    end
    in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (width_valid) seen = 1'b1;
    end
    check("t6_no_stale_wv", seen, 0);
    check("t6_fell", out_filt, 0);
    step(1);
    check("t6_wv", width_valid, 1);
    check("t6_high_width", high_width, 10);

    // clr coincident with rise_pulse; later clr mid-measurement restarts the width.
    in = 1'b1;
    step(4);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("t7_out_filt", out_filt, 1);
    check("t7_rise_pulse", rise_pulse, 1);
    check("t7_rise_cnt_dropped", rise_cnt, 0);
    check("t7_fall_cnt_cleared", fall_cnt, 0);
    step(3);
    check("t7_rise_cnt_still0", rise_cnt, 0);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(1);
    in = 1'b0;
    step(5);
    check("t7_fell", out_filt, 0);
    check("t7_fall_cnt", fall_cnt, 1);
    step(1);
    check("t7_wv", width_valid, 1);
    check("t7_high_width_restart", high_width, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
